// File: rtl/rtc_bus_scheduler.sv
// Multiplexed RTC bus sequencer: CPU single-register accesses plus periodic shadow scans,
// one six-phase bus transaction at a time, with CPU priority bounded by a starvation guard.
module rtc_bus_scheduler #(
    parameter int         T_PHASE     = 10,
    parameter int         REFRESH_DIV = 1000000,
    parameter logic [7:0] SCAN_BASE   = 8'h21,
    parameter int         NREG        = 6
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    output logic       cpu_busy,
    input  logic       scan_en,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       rtc_as_n,
    output logic       rtc_cs_n,
    output logic       rtc_rd_n,
    output logic       rtc_wr_n,
    output logic       shadow_wr,
    output logic [2:0] shadow_idx,
    output logic [7:0] shadow_data,
    output logic       scan_done
);

    // state   | meaning
    // IDLE    | bus released, arbitrate CPU vs scan
    // ASET    | cs/as low, address driven
    // AHOLD   | as high, address held
    // GAP     | bus turnaround (write data driven for writes)
    // STROBE  | rd_n or wr_n low, read data sampled on last clock
    // RECOVER | strobes and cs high, bus released
    typedef enum logic [2:0] {IDLE, ASET, AHOLD, GAP, STROBE, RECOVER} state_t;

    localparam int             RW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [7:0]     PH_LOAD  = 8'(T_PHASE - 1);
    localparam logic [RW-1:0]  REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [2:0]     IDX_LAST = 3'(NREG - 1);

    state_t        state_q;
    logic [7:0]    phase_q;
    logic [RW-1:0] refresh_q, refresh_d;
    logic          scan_pend_q, scan_pend_d;
    logic          cpu_pend_q, cpu_pend_d;
    logic          req_we_q;
    logic [7:0]    req_addr_q, req_wdata_q;
    logic          cur_we_q, cpu_svc_q;
    logic [7:0]    cur_wdata_q, sample_q;
    logic [1:0]    consec_q;
    logic [2:0]    scan_idx_q;
    logic [7:0]    rdata_q, ad_out_q, shadow_data_q;
    logic [2:0]    shadow_idx_q;
    logic          ack_q, shadow_wr_q, scan_done_q, ad_oe_q;
    logic          as_n_q, cs_n_q, rd_n_q, wr_n_q;

    logic phase_end, svc_done, cpu_accept, grant_scan, grant_cpu, scan_last, refresh_tc;

    always_comb begin
        phase_end  = (phase_q == 8'd0);
        svc_done   = (state_q == RECOVER) && phase_end;
        // A CPU transaction is finished on its last RECOVER clock, so a request there is taken.
        cpu_accept = cpu_req && !cpu_pend_q && (!cpu_svc_q || svc_done);
        grant_scan = (state_q == IDLE) && scan_pend_q && (!cpu_pend_q || consec_q == 2'd2);
        grant_cpu  = (state_q == IDLE) && cpu_pend_q && !grant_scan;
        scan_last  = svc_done && !cpu_svc_q && (scan_idx_q == IDX_LAST);
        refresh_tc = scan_en && (refresh_q == REF_LAST);

        refresh_d = refresh_q;
        if (!scan_en || refresh_tc) refresh_d = '0;
        else                        refresh_d = refresh_q + 1'b1;

        scan_pend_d = scan_pend_q;
        if (scan_last)       scan_pend_d = 1'b0;
        else if (refresh_tc) scan_pend_d = 1'b1;

        cpu_pend_d = cpu_pend_q;
        if (cpu_accept)     cpu_pend_d = 1'b1;
        else if (grant_cpu) cpu_pend_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= IDLE;
            phase_q       <= 8'd0;
            refresh_q     <= '0;
            scan_pend_q   <= 1'b0;
            cpu_pend_q    <= 1'b0;
            req_we_q      <= 1'b0;
            req_addr_q    <= 8'd0;
            req_wdata_q   <= 8'd0;
            cur_we_q      <= 1'b0;
            cpu_svc_q     <= 1'b0;
            cur_wdata_q   <= 8'd0;
            sample_q      <= 8'd0;
            consec_q      <= 2'd0;
            scan_idx_q    <= 3'd0;
            rdata_q       <= 8'd0;
            ad_out_q      <= 8'd0;
            shadow_data_q <= 8'd0;
            shadow_idx_q  <= 3'd0;
            ack_q         <= 1'b0;
            shadow_wr_q   <= 1'b0;
            scan_done_q   <= 1'b0;
            ad_oe_q       <= 1'b0;
            as_n_q        <= 1'b1;
            cs_n_q        <= 1'b1;
            rd_n_q        <= 1'b1;
            wr_n_q        <= 1'b1;
        end else begin
            refresh_q   <= refresh_d;
            scan_pend_q <= scan_pend_d;
            cpu_pend_q  <= cpu_pend_d;
            ack_q       <= 1'b0;
            shadow_wr_q <= 1'b0;
            scan_done_q <= 1'b0;

            if (cpu_accept) begin
                req_we_q    <= cpu_we;
                req_addr_q  <= cpu_addr;
                req_wdata_q <= cpu_wdata;
            end

            if (state_q != IDLE) begin
                phase_q <= phase_end ? PH_LOAD : phase_q - 8'd1;
            end

            case (state_q)
                IDLE: begin
                    if (grant_cpu || grant_scan) begin
                        state_q <= ASET;
                        phase_q <= PH_LOAD;
                        cs_n_q  <= 1'b0;
                        as_n_q  <= 1'b0;
                        ad_oe_q <= 1'b1;
                        if (grant_cpu) begin
                            cur_we_q    <= req_we_q;
                            cur_wdata_q <= req_wdata_q;
                            ad_out_q    <= req_addr_q;
                            cpu_svc_q   <= 1'b1;
                            if (scan_pend_q) consec_q <= consec_q + 2'd1;
                        end else begin
                            cur_we_q  <= 1'b0;
                            ad_out_q  <= SCAN_BASE + {5'd0, scan_idx_q};
                            cpu_svc_q <= 1'b0;
                            consec_q  <= 2'd0;
                        end
                    end
                end
                ASET: if (phase_end) begin
                    state_q <= AHOLD;
                    as_n_q  <= 1'b1;
                end
                AHOLD: if (phase_end) begin
                    state_q <= GAP;
                    if (cur_we_q) ad_out_q <= cur_wdata_q;
                    else          ad_oe_q  <= 1'b0;
                end
                GAP: if (phase_end) begin
                    state_q <= STROBE;
                    rd_n_q  <= cur_we_q;
                    wr_n_q  <= !cur_we_q;
                end
                STROBE: if (phase_end) begin
                    state_q <= RECOVER;
                    rd_n_q  <= 1'b1;
                    wr_n_q  <= 1'b1;
                    cs_n_q  <= 1'b1;
                    ad_oe_q <= 1'b0;
                    if (!cur_we_q) sample_q <= ad_in;
                end
                RECOVER: if (phase_end) begin
                    state_q <= IDLE;
                    if (cpu_svc_q) begin
                        ack_q     <= 1'b1;
                        cpu_svc_q <= 1'b0;
                        if (!cur_we_q) rdata_q <= sample_q;
                    end else begin
                        shadow_wr_q   <= 1'b1;
                        shadow_idx_q  <= scan_idx_q;
                        shadow_data_q <= sample_q;
                        if (scan_idx_q == IDX_LAST) begin
                            scan_done_q <= 1'b1;
                            scan_idx_q  <= 3'd0;
                        end else begin
                            scan_idx_q <= scan_idx_q + 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata   = rdata_q;
    assign cpu_ack     = ack_q;
    assign cpu_busy    = cpu_pend_q | cpu_svc_q;
    assign ad_out      = ad_out_q;
    assign ad_oe       = ad_oe_q;
    assign rtc_as_n    = as_n_q;
    assign rtc_cs_n    = cs_n_q;
    assign rtc_rd_n    = rd_n_q;
    assign rtc_wr_n    = wr_n_q;
    assign shadow_wr   = shadow_wr_q;
    assign shadow_idx  = shadow_idx_q;
    assign shadow_data = shadow_data_q;
    assign scan_done   = scan_done_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler: CPU vector table, scan sequence, arbitration,
// ignored-request and mid-transaction reset corner cases.
module tb_rtc_bus_scheduler;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = 8'd0, cpu_wdata = 8'd0;
    logic [7:0] cpu_rdata;
    logic       cpu_ack, cpu_busy;
    logic       scan_en = 1'b0;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;
    logic       rtc_as_n, rtc_cs_n, rtc_rd_n, rtc_wr_n;
    logic       shadow_wr, scan_done;
    logic [2:0] shadow_idx;
    logic [7:0] shadow_data;

    logic       ad_auto = 1'b0;
    logic [7:0] ad_in_fix = 8'd0;
    logic [7:0] last_addr = 8'd0;
    logic       prev_as = 1'b1;
    logic [7:0] addr_log[$];
    logic [2:0] sh_idx[$];
    logic [7:0] sh_data[$];
    logic       sh_done[$];
    int         done_cnt = 0;
    int         ack_cnt = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    assign ad_in = ad_auto ? (last_addr ^ 8'hA5) : ad_in_fix;

    always #5 CLK = ~CLK;

    rtc_bus_scheduler #(.T_PHASE(10), .REFRESH_DIV(100), .SCAN_BASE(8'h21), .NREG(6)) dut (
        .CLK(CLK), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
        .scan_en(scan_en), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
        .rtc_as_n(rtc_as_n), .rtc_cs_n(rtc_cs_n), .rtc_rd_n(rtc_rd_n), .rtc_wr_n(rtc_wr_n),
        .shadow_wr(shadow_wr), .shadow_idx(shadow_idx), .shadow_data(shadow_data),
        .scan_done(scan_done)
    );

    always @(negedge CLK) begin
        if (prev_as && !rtc_as_n) begin
            addr_log.push_back(ad_out);
            last_addr = ad_out;
        end
        prev_as = rtc_as_n;
        if (shadow_wr) begin
            sh_idx.push_back(shadow_idx);
            sh_data.push_back(shadow_data);
            sh_done.push_back(scan_done);
        end
        if (scan_done) done_cnt++;
        if (cpu_ack) ack_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_cpu(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] adin,
                           output int ack_at, output int as_first, output int as_low,
                           output int rd_low, output int wr_low, output int acks,
                           output logic [7:0] aout_aset, output logic [7:0] aout_ahold,
                           output logic [7:0] aout_gap, output logic oe_gap);
        ack_at = 0; as_first = 0; as_low = 0; rd_low = 0; wr_low = 0; acks = 0;
        aout_aset = 8'd0; aout_ahold = 8'd0; aout_gap = 8'd0; oe_gap = 1'b0;
        ad_auto = 1'b0;
        ad_in_fix = adin;
        @(negedge CLK);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge CLK); #1;
        cpu_req = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            @(posedge CLK); #1;
            if (!rtc_as_n) begin
                as_low++;
                if (as_first == 0) as_first = n;
            end
            if (!rtc_rd_n) rd_low++;
            if (!rtc_wr_n) wr_low++;
            if (cpu_ack) begin
                acks++;
                if (ack_at == 0) ack_at = n;
            end
            if (n == 1)  aout_aset = ad_out;
            if (n == 11) aout_ahold = ad_out;
            if (n == 21) begin
                aout_gap = ad_out;
                oe_gap = ad_oe;
            end
        end
    endtask

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] adin;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int ack_at, as_first, as_low, rd_low, wr_low, acks;
        logic [7:0] a_aset, a_ahold, a_gap;
        logic oe_g;
        int done0, acks0, logsz0, busy_low, pos_prev, nscan;
        int scan_pos[$];

        vecs[0] = '{1'b0, 8'h0B, 8'h00, 8'h5A, 8'h5A};
        vecs[1] = '{1'b1, 8'h0A, 8'h26, 8'hEE, 8'h5A};
        vecs[2] = '{1'b0, 8'h33, 8'h00, 8'hC3, 8'hC3};
        vecs[3] = '{1'b1, 8'h7F, 8'h00, 8'h11, 8'hC3};
        vecs[4] = '{1'b0, 8'hFF, 8'h99, 8'h00, 8'h00};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_strobes", {rtc_as_n, rtc_cs_n, rtc_rd_n, rtc_wr_n}, 4'hF);
        chk("rst_ad_oe", ad_oe, 0);
        chk("rst_ad_out", ad_out, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_pulses", {cpu_ack, shadow_wr, scan_done, cpu_busy}, 0);

        for (int v = 0; v < 5; v++) begin
            run_cpu(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].adin,
                    ack_at, as_first, as_low, rd_low, wr_low, acks, a_aset, a_ahold, a_gap, oe_g);
            chk($sformatf("v%0d_ack_at", v), ack_at, 51);
            chk($sformatf("v%0d_acks", v), acks, 1);
            chk($sformatf("v%0d_aset_at", v), as_first, 1);
            chk($sformatf("v%0d_as_low", v), as_low, 10);
            chk($sformatf("v%0d_rd_low", v), rd_low, vecs[v].we ? 0 : 10);
            chk($sformatf("v%0d_wr_low", v), wr_low, vecs[v].we ? 10 : 0);
            chk($sformatf("v%0d_addr_aset", v), a_aset, vecs[v].addr);
            chk($sformatf("v%0d_addr_ahold", v), a_ahold, vecs[v].addr);
            chk($sformatf("v%0d_oe_gap", v), oe_g, vecs[v].we);
            if (vecs[v].we) chk($sformatf("v%0d_wdata_gap", v), a_gap, vecs[v].wdata);
            chk($sformatf("v%0d_rdata", v), cpu_rdata, vecs[v].exp_rdata);
        end

        // Full scan with no CPU traffic
        addr_log.delete(); sh_idx.delete(); sh_data.delete(); sh_done.delete();
        ad_auto = 1'b1;
        done0 = done_cnt;
        @(negedge CLK);
        scan_en = 1'b1;
        for (int i = 0; i < 1000 && done_cnt == done0; i++) @(posedge CLK);
        @(negedge CLK);
        scan_en = 1'b0;
        chk("scan_done_cnt", done_cnt - done0, 1);
        chk("scan_reads", addr_log.size(), 6);
        chk("scan_shadow_cnt", sh_idx.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < addr_log.size()) chk($sformatf("scan_addr%0d", i), addr_log[i], 8'h21 + i);
            if (i < sh_idx.size()) begin
                chk($sformatf("scan_idx%0d", i), sh_idx[i], i);
                chk($sformatf("scan_data%0d", i), sh_data[i], (8'h21 + i) ^ 8'hA5);
                chk($sformatf("scan_donef%0d", i), sh_done[i], (i == 5) ? 1 : 0);
            end
        end

        // Continuous CPU requests during scan: CPU, CPU, scan interleaving
        repeat (20) @(posedge CLK);
        addr_log.delete();
        done0 = done_cnt;
        @(negedge CLK);
        cpu_we = 1'b0; cpu_addr = 8'h05; cpu_req = 1'b1; scan_en = 1'b1;
        for (int i = 0; i < 4000 && done_cnt == done0; i++) @(posedge CLK);
        @(negedge CLK);
        cpu_req = 1'b0; scan_en = 1'b0;
        chk("arb_done_cnt", done_cnt - done0, 1);
        for (int i = 0; i < 300 && cpu_busy; i++) @(posedge CLK);
        repeat (60) @(posedge CLK);
        #1;
        chk("arb_drained", cpu_busy, 0);
        for (int i = 0; i < addr_log.size(); i++)
            if (addr_log[i] >= 8'h21 && addr_log[i] <= 8'h26) scan_pos.push_back(i);
        nscan = scan_pos.size();
        chk("arb_scan_cnt", nscan, 6);
        chk("arb_pre_cpu", (nscan > 0 && scan_pos[0] >= 2) ? 1 : 0, 1);
        pos_prev = -1;
        for (int k = 0; k < nscan; k++) begin
            chk($sformatf("arb_scan_addr%0d", k), addr_log[scan_pos[k]], 8'h21 + k);
            if (k > 0) chk($sformatf("arb_gap%0d", k), scan_pos[k] - pos_prev, 3);
            pos_prev = scan_pos[k];
        end

        // Second request while in service is ignored
        ad_auto = 1'b0;
        ad_in_fix = 8'h77;
        acks0 = ack_cnt;
        logsz0 = addr_log.size();
        busy_low = 0;
        @(negedge CLK);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h11;
        @(posedge CLK); #1;
        cpu_req = 1'b0;
        if (!cpu_busy) busy_low++;
        for (int n = 1; n <= 100; n++) begin
            @(posedge CLK); #1;
            if (n == 20) begin
                cpu_req = 1'b1; cpu_addr = 8'h44; ad_in_fix = 8'h99;
            end else begin
                cpu_req = 1'b0;
            end
            if (n <= 50 && !cpu_busy) busy_low++;
            if (n == 52) chk("dup_busy_after", cpu_busy, 0);
        end
        chk("dup_busy_low", busy_low, 0);
        chk("dup_acks", ack_cnt - acks0, 1);
        chk("dup_txns", addr_log.size() - logsz0, 1);
        chk("dup_rdata", cpu_rdata, 8'h99);

        // Reset during STROBE of a write aborts it
        acks0 = ack_cnt;
        @(negedge CLK);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h0A; cpu_wdata = 8'h26;
        @(posedge CLK); #1;
        cpu_req = 1'b0;
        repeat (35) begin
            @(posedge CLK); #1;
        end
        chk("rst_mid_wr_low", rtc_wr_n, 0);
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK); #1;
        chk("rst_mid_wr_n", rtc_wr_n, 1);
        chk("rst_mid_cs_n", rtc_cs_n, 1);
        chk("rst_mid_oe", ad_oe, 0);
        @(negedge CLK);
        reset = 1'b0;
        repeat (60) @(posedge CLK);
        #1;
        chk("rst_mid_no_ack", ack_cnt - acks0, 0);
        chk("rst_mid_rdata", cpu_rdata, 0);
        run_cpu(1'b0, 8'h0B, 8'h00, 8'h5A,
                ack_at, as_first, as_low, rd_low, wr_low, acks, a_aset, a_ahold, a_gap, oe_g);
        chk("post_rst_ack_at", ack_at, 51);
        chk("post_rst_rdata", cpu_rdata, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
